sr_register_bank: RTL and testbench

SR_REGISTER_BANK -- requirements
Module: sr_register_bank

---
 rtl/sr_bank_pkg.sv | 11 +
 rtl/sr_register_bank_cell.sv | 32 +++
 rtl/sr_register_bank.sv | 84 ++++++++
 tb/tb_sr_register_bank.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sr_bank_pkg.sv
// Shared definitions for the SR register bank: S=R=1 resolution modes.
package sr_bank_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD    = 2'b00,
        MODE_SET_PRI = 2'b01,
        MODE_RST_PRI = 2'b10,
        MODE_TOGGLE  = 2'b11
    } mode_e;

endpackage

// File: rtl/sr_register_bank_cell.sv
// Single SR channel: combinational next-state and conflict detection.
module sr_cell
    import sr_bank_pkg::*;
(
    input  logic       s,
    input  logic       r,
    input  logic       q,
    input  logic [1:0] mode,
    output logic       q_next,
    output logic       conflict_hit
);

    always_comb begin
        q_next       = q;
        conflict_hit = s & r;
        unique case ({s, r})
            2'b10: q_next = 1'b1;
            2'b01: q_next = 1'b0;
            2'b11: begin
                unique case (mode_e'(mode))
                    MODE_HOLD:    q_next = q;
                    MODE_SET_PRI: q_next = 1'b1;
                    MODE_RST_PRI: q_next = 1'b0;
                    MODE_TOGGLE:  q_next = ~q;
                    default:      q_next = q;
                endcase
            end
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/sr_register_bank.sv
// Bank of WIDTH SR channels with edge pulses, sticky conflict flags and a
// saturating conflict-cycle counter.
module sr_register_bank
    import sr_bank_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       CNT_W     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_conflict,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] conflict_q, conflict_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_next_vec;
    logic [WIDTH-1:0] hit_vec;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell u_cell (
            .s            (s[i]),
            .r            (r[i]),
            .q            (q_q[i]),
            .mode         (mode),
            .q_next       (q_next_vec[i]),
            .conflict_hit (hit_vec[i])
        );
    end

    logic [WIDTH-1:0] hit_en;
    logic [CNT_W-1:0] cnt_base;

    always_comb begin
        q_d    = en ? q_next_vec : q_q;
        hit_en = en ? hit_vec : '0;
        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;
        // Clear is applied first so a same-edge conflict wins over it.
        conflict_d = (clr_conflict ? '0 : conflict_q) | hit_en;
        cnt_base   = clr_conflict ? '0 : cnt_q;
        cnt_d      = cnt_base;
        if (|hit_en && cnt_base != CNT_MAX) begin
            cnt_d = cnt_base + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q        <= RESET_VAL;
            rise_q     <= '0;
            fall_q     <= '0;
            conflict_q <= '0;
            cnt_q      <= '0;
        end else begin
            q_q        <= q_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    assign q            = q_q;
    assign q_rise       = rise_q;
    assign q_fall       = fall_q;
    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_register_bank.sv
// Bench for sr_register_bank: two instances (8-bit and 2-bit counters) driven
// by the same directed vectors, checked against a behavioural model each cycle.
module tb_sr_register_bank;

    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [7:0] s, r;
    logic       clr_conflict;

    logic [7:0] q_a, rise_a, fall_a, conf_a;
    logic [7:0] cnt_a;
    logic [7:0] q_b, rise_b, fall_b, conf_b;
    logic [1:0] cnt_b;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    sr_register_bank #(.WIDTH(8), .CNT_W(8), .RESET_VAL(RV)) dut_a (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .s(s), .r(r),
        .clr_conflict(clr_conflict), .q(q_a), .q_rise(rise_a), .q_fall(fall_a),
        .conflict(conf_a), .conflict_cnt(cnt_a)
    );

    sr_register_bank #(.WIDTH(8), .CNT_W(2), .RESET_VAL(RV)) dut_b (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .s(s), .r(r),
        .clr_conflict(clr_conflict), .q(q_b), .q_rise(rise_b), .q_fall(fall_b),
        .conflict(conf_b), .conflict_cnt(cnt_b)
    );

    // Behavioural model
    logic [7:0] m_q, m_rise, m_fall, m_conf;
    int         m_cnt8, m_cnt2;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q = RV; m_rise = '0; m_fall = '0; m_conf = '0;
            m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            logic [7:0] nq;
            bit any;
            nq  = m_q;
            any = 1'b0;
            if (clr_conflict) begin
                m_conf = '0; m_cnt8 = 0; m_cnt2 = 0;
            end
            if (en) begin
                for (int i = 0; i < 8; i++) begin
                    if (s[i] && !r[i]) nq[i] = 1'b1;
                    else if (!s[i] && r[i]) nq[i] = 1'b0;
                    else if (s[i] && r[i]) begin
                        any = 1'b1;
                        m_conf[i] = 1'b1;
                        if (mode == 2'd1) nq[i] = 1'b1;
                        else if (mode == 2'd2) nq[i] = 1'b0;
                        else if (mode == 2'd3) nq[i] = ~m_q[i];
                    end
                end
            end
            if (any) begin
                m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
            m_rise = nq & ~m_q;
            m_fall = ~nq & m_q;
            m_q    = nq;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc q_a",    q_a,    m_q);
            check("cyc rise_a", rise_a, m_rise);
            check("cyc fall_a", fall_a, m_fall);
            check("cyc conf_a", conf_a, m_conf);
            check("cyc cnt_a",  cnt_a,  64'(m_cnt8));
            check("cyc q_b",    q_b,    m_q);
            check("cyc rise_b", rise_b, m_rise);
            check("cyc fall_b", fall_b, m_fall);
            check("cyc conf_b", conf_b, m_conf);
            check("cyc cnt_b",  cnt_b,  64'(m_cnt2));
        end
    end

    // Called just after a negedge: drive, then wait through one posedge.
    task automatic step(input logic e, input logic [1:0] m, input logic [7:0] sv,
                        input logic [7:0] rv, input logic c);
        en = e; mode = m; s = sv; r = rv; clr_conflict = c;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 2'd0; s = '0; r = '0; clr_conflict = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;
        check("rst q", q_a, 8'hA5);
        check("rst cnt", cnt_a, 8'd0);

        step(1'b1, 2'd0, 8'h00, 8'hFF, 1'b0);
        check("clear q", q_a, 8'h00);
        check("clear fall", fall_a, 8'hA5);
        step(1'b1, 2'd0, 8'h0F, 8'hF0, 1'b0);
        check("set q", q_a, 8'h0F);
        check("set rise", rise_a, 8'h0F);
        check("set cnt", cnt_a, 8'd0);
        step(1'b1, 2'd0, 8'h00, 8'h00, 1'b0);
        check("hold rise", rise_a, 8'h00);
        step(1'b1, 2'd0, 8'h00, 8'hFF, 1'b0);

        for (int m = 0; m < 4; m++) begin
            logic [2:0] expq;
            case (m)
                0: expq = 3'b000;
                1: expq = 3'b111;
                2: expq = 3'b000;
                default: expq = 3'b101;
            endcase
            step(1'b1, 2'(m), 8'h00, 8'h01, 1'b1);
            for (int k = 0; k < 3; k++) begin
                step(1'b1, 2'(m), 8'h01, 8'h01, 1'b0);
                check("mode q0", q_a[0], expq[2-k]);
            end
            check("mode conf", conf_a, 8'h01);
            check("mode cnt", cnt_a, 8'd3);
        end

        step(1'b1, 2'd0, 8'h00, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b1, 2'd0, 8'h01, 8'h01, 1'b0);
        check("sat cnt_b", cnt_b, 2'd3);
        check("sat cnt_a", cnt_a, 8'd5);

        step(1'b1, 2'd0, 8'h80, 8'h80, 1'b1);
        check("clrhit conf", conf_a, 8'h80);
        check("clrhit cnt", cnt_a, 8'd1);
        step(1'b1, 2'd0, 8'h00, 8'h00, 1'b1);
        check("clr conf", conf_a, 8'h00);
        check("clr cnt", cnt_a, 8'd0);

        step(1'b1, 2'd1, 8'h01, 8'h01, 1'b0);
        check("pre q", q_a, 8'h01);
        step(1'b0, 2'd3, 8'hFF, 8'hFF, 1'b0);
        check("dis q", q_a, 8'h01);
        check("dis conf", conf_a, 8'h01);
        check("dis cnt", cnt_a, 8'd1);
        check("dis rise", rise_a, 8'h00);
        check("dis fall", fall_a, 8'h00);
        step(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
        check("dis clr conf", conf_a, 8'h00);
        check("dis clr cnt", cnt_a, 8'd0);

        step(1'b1, 2'd3, 8'hFF, 8'hFF, 1'b0);
        check("tog q", q_a, 8'hFE);
        check("tog rise", rise_a, 8'hFE);
        check("tog fall", fall_a, 8'h01);
        check("tog conf", conf_a, 8'hFF);

        en = 1'b1; mode = 2'd1; s = 8'h01; r = 8'h01;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid rst q", q_a, 8'hA5);
        check("mid rst rise", rise_a, 8'h00);
        check("mid rst fall", fall_a, 8'h00);
        check("mid rst conf", conf_a, 8'h00);
        check("mid rst cnt", cnt_a, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 2'd0, 8'h00, 8'h00, 1'b0);
        check("post rst rise", rise_a, 8'h00);
        check("post rst fall", fall_a, 8'h00);
        step(1'b1, 2'd0, 8'hFF, 8'h00, 1'b0);
        check("post rst q", q_a, 8'hFF);
        check("post rst rise2", rise_a, 8'h5A);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
